// File: rtl/uart_core.sv
// Full-duplex UART: a transmitter with a valid/ready word input, and a receiver that
// produces a one-cycle strobe with parity and framing flags. TX and RX share only clk and reset.
module uart_core #(
  parameter int CLKS_PER_BIT = 234,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);
  localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_FULL  = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_PRE   = CW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] BIT_HALF  = CW'(CLKS_PER_BIT / 2);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  // ---------------- transmitter ----------------
  tx_state_t           tx_st, tx_nxt;
  logic [CW-1:0]       tx_cnt, tx_cnt_n;
  logic [2:0]          tx_idx, tx_idx_n, tx_idx_inc;
  logic [DATA_BITS-1:0] tx_sr, tx_sr_n;
  logic                tx_bit_n, tx_par;

  assign tx_ready   = (tx_st == TX_IDLE);
  assign tx_idx_inc = tx_idx + 3'd1;
  assign tx_par     = (^tx_sr) ^ PAR_ODD;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_st   <= TX_IDLE;
      tx_cnt  <= '0;
      tx_idx  <= '0;
      tx_sr   <= '0;
      uart_tx <= 1'b1;
    end else begin
      tx_st   <= tx_nxt;
      tx_cnt  <= tx_cnt_n;
      tx_idx  <= tx_idx_n;
      tx_sr   <= tx_sr_n;
      uart_tx <= tx_bit_n;
    end
  end

  // The last stop cycle is spent back in IDLE so a word accepted there starts with no gap.
  always_comb begin
    tx_nxt   = tx_st;
    tx_cnt_n = tx_cnt + CW'(1);
    tx_idx_n = tx_idx;
    tx_sr_n  = tx_sr;
    tx_bit_n = uart_tx;
    case (tx_st)
      TX_IDLE: begin
        tx_cnt_n = '0;
        tx_bit_n = 1'b1;
        if (tx_valid) begin
          tx_nxt   = TX_START;
          tx_sr_n  = tx_data;
          tx_idx_n = '0;
          tx_bit_n = 1'b0;
        end
      end
      TX_START: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n = '0;
        tx_nxt   = TX_DATA;
        tx_bit_n = tx_sr[0];
      end
      TX_DATA: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n = '0;
        if (tx_idx == DATA_LAST) begin
          tx_idx_n = '0;
          if (PARITY != 0) begin
            tx_nxt   = TX_PAR;
            tx_bit_n = tx_par;
          end else begin
            tx_nxt   = TX_STOP;
            tx_bit_n = 1'b1;
          end
        end else begin
          tx_idx_n = tx_idx_inc;
          tx_bit_n = tx_sr[tx_idx_inc];
        end
      end
      TX_PAR: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n = '0;
        tx_nxt   = TX_STOP;
        tx_bit_n = 1'b1;
      end
      TX_STOP: begin
        if (tx_idx == STOP_LAST && tx_cnt == BIT_PRE) begin
          tx_cnt_n = '0;
          tx_nxt   = TX_IDLE;
        end else if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          tx_idx_n = tx_idx_inc;
        end
      end
      default: tx_nxt = TX_IDLE;
    endcase
  end

  // ---------------- receiver ----------------
  rx_state_t            rx_st, rx_nxt;
  logic [1:0]           rx_sync;
  logic                 rx_s;
  logic [CW-1:0]        rx_cnt, rx_cnt_n;
  logic [2:0]           rx_idx, rx_idx_n;
  logic [DATA_BITS-1:0] rx_sr, rx_sr_n;
  logic                 rx_perr, rx_perr_n, rx_ferr, rx_ferr_n, rx_done;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync       <= 2'b11;
      rx_st         <= RX_IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_sr         <= '0;
      rx_perr       <= 1'b0;
      rx_ferr       <= 1'b0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], uart_rx};
      rx_st    <= rx_nxt;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_sr    <= rx_sr_n;
      rx_perr  <= rx_perr_n;
      rx_ferr  <= rx_ferr_n;
      rx_valid <= rx_done;
      if (rx_done) begin
        rx_data       <= rx_sr;
        rx_parity_err <= (PARITY != 0) && rx_perr;
        rx_frame_err  <= rx_ferr_n;
      end
    end
  end

  always_comb begin
    rx_nxt    = rx_st;
    rx_cnt_n  = rx_cnt + CW'(1);
    rx_idx_n  = rx_idx;
    rx_sr_n   = rx_sr;
    rx_perr_n = rx_perr;
    rx_ferr_n = rx_ferr;
    rx_done   = 1'b0;
    case (rx_st)
      RX_IDLE: begin
        rx_cnt_n  = CW'(1);
        rx_idx_n  = '0;
        rx_perr_n = 1'b0;
        rx_ferr_n = 1'b0;
        if (!rx_s) rx_nxt = RX_START;
      end
      RX_START: if (rx_cnt == BIT_HALF) begin
        rx_cnt_n = CW'(1);
        rx_nxt   = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt == BIT_FULL) begin
        rx_cnt_n = CW'(1);
        rx_sr_n  = {rx_s, rx_sr[DATA_BITS-1:1]};
        if (rx_idx == DATA_LAST) begin
          rx_idx_n = '0;
          rx_nxt   = (PARITY != 0) ? RX_PAR : RX_STOP;
        end else begin
          rx_idx_n = rx_idx + 3'd1;
        end
      end
      RX_PAR: if (rx_cnt == BIT_FULL) begin
        rx_cnt_n  = CW'(1);
        rx_perr_n = (^rx_sr) ^ rx_s ^ PAR_ODD;
        rx_nxt    = RX_STOP;
      end
      RX_STOP: if (rx_cnt == BIT_FULL) begin
        rx_cnt_n  = CW'(1);
        rx_ferr_n = rx_ferr | ~rx_s;
        if (rx_idx == STOP_LAST) begin
          rx_done = 1'b1;
          rx_nxt  = rx_s ? RX_IDLE : RX_WAIT_HIGH;
        end else begin
          rx_idx_n = rx_idx + 3'd1;
        end
      end
      RX_WAIT_HIGH: begin
        rx_cnt_n = CW'(1);
        if (rx_s) rx_nxt = RX_IDLE;
      end
      default: rx_nxt = RX_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: three instances (8N1 driven serially, 8E2 in loopback, 7O1 driven
// serially) checked against frames and parity computed from the UART frame rules.
`timescale 1ns/1ps
module tb_uart_core;
  localparam int CPB   = 16;
  localparam int BITNS = CPB * 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic       rx0, tx0, txv0, txr0, rxv0, pe0, fe0;
  logic [7:0] txd0, rxd0;
  logic       tx1, txv1, txr1, rxv1, pe1, fe1;
  logic [7:0] txd1, rxd1;
  logic       rx2, tx2, txv2, txr2, rxv2, pe2, fe2;
  logic [6:0] txd2, rxd2;

  uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset_n(reset_n), .uart_rx(rx0), .uart_tx(tx0), .tx_data(txd0),
    .tx_valid(txv0), .tx_ready(txr0), .rx_data(rxd0), .rx_valid(rxv0),
    .rx_parity_err(pe0), .rx_frame_err(fe0));
  uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .reset_n(reset_n), .uart_rx(tx1), .uart_tx(tx1), .tx_data(txd1),
    .tx_valid(txv1), .tx_ready(txr1), .rx_data(rxd1), .rx_valid(rxv1),
    .rx_parity_err(pe1), .rx_frame_err(fe1));
  uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .reset_n(reset_n), .uart_rx(rx2), .uart_tx(tx2), .tx_data(txd2),
    .tx_valid(txv2), .tx_ready(txr2), .rx_data(rxd2), .rx_valid(rxv2),
    .rx_parity_err(pe2), .rx_frame_err(fe2));

  // strobe records: {frame_err, parity_err, data}
  logic [9:0] q0[$], q1[$], q2[$];
  always @(negedge clk) begin
    if (rxv0) q0.push_back({fe0, pe0, rxd0});
    if (rxv1) q1.push_back({fe1, pe1, rxd1});
    if (rxv2) q2.push_back({fe2, pe2, 1'b0, rxd2});
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic par_bit(input logic [7:0] d, input int nb, input int mode);
    int ones = 0;
    for (int i = 0; i < nb; i++) if (d[i]) ones++;
    return (mode == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
  endfunction

  // frame bit i of an unparitied frame: start, data LSB first, then stop/idle ones
  function automatic logic fbit(input logic [7:0] d, input int i, input int nb);
    if (i == 0) return 1'b0;
    if (i <= nb) return d[i-1];
    return 1'b1;
  endfunction

  task automatic set_line(input int sel, input logic b);
    if (sel == 0) rx0 = b; else rx2 = b;
  endtask

  task automatic drive_frame(input int sel, input logic [7:0] d, input int nb, input int mode,
                             input int stops, input logic bad_par, input int per_ns);
    for (int i = 0; i <= nb; i++) begin
      set_line(sel, fbit(d, i, nb));
      #(per_ns);
    end
    if (mode != 0) begin
      set_line(sel, par_bit(d, nb, mode) ^ bad_par);
      #(per_ns);
    end
    for (int i = 0; i < stops + 1; i++) begin
      set_line(sel, 1'b1);
      #(per_ns);
    end
  endtask

  function automatic int qsz(input int sel);
    if (sel == 0) return q0.size();
    if (sel == 1) return q1.size();
    return q2.size();
  endfunction

  task automatic wait_q(input int sel, input int n, input int budget, input string tag);
    int k = 0;
    while (qsz(sel) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(qsz(sel)), 32'(n));
  endtask

  task automatic expect_rx(input int sel, input string tag, input logic [9:0] exp);
    logic [9:0] got;
    wait_q(sel, 1, 200, {tag, "_count"});
    if (qsz(sel) > 0) begin
      if (sel == 0) got = q0.pop_front();
      else if (sel == 1) got = q1.pop_front();
      else got = q2.pop_front();
      chk(tag, 32'(got), 32'(exp));
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rdy_at, errs, k;
    int acc[8];
    logic [7:0] words[8];
    logic [7:0] d;
    logic       bad, eb;

    rx0 = 1'b1; rx2 = 1'b1;
    txv0 = 1'b0; txd0 = '0; txv1 = 1'b0; txd1 = '0; txv2 = 1'b0; txd2 = '0;

    // reset state while clock runs
    #23;
    chk("rst_uart_tx", 32'(tx0), 1);
    chk("rst_tx_ready", 32'(txr0), 1);
    chk("rst_rx_valid", 32'(rxv0), 0);
    chk("rst_rx_data", 32'(rxd0), 0);
    chk("rst_perr", 32'(pe0), 0);
    chk("rst_ferr", 32'(fe0), 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // single 8N1 transmit of 0xA5
    txd0 = 8'hA5; txv0 = 1'b1;
    @(negedge clk);
    txv0 = 1'b0; txd0 = 8'hFF;
    chk("tx_ready_drop", 32'(txr0), 0);
    rdy_at = 0; errs = 0;
    for (int j = 1; j <= 400 && rdy_at == 0; j++) begin
      if (j > 1) @(negedge clk);
      if (txr0) rdy_at = j;
      else begin
        eb = fbit(8'hA5, (j - 1) / CPB, 8);
        if (tx0 !== eb) errs++;
        if ((j - 1) % CPB == CPB / 2) chk($sformatf("tx_bit%0d", (j - 1) / CPB), 32'(tx0), 32'(eb));
      end
    end
    chk("tx_ready_return", 32'(rdy_at), 160);
    chk("tx_bits_exact", 32'(errs), 0);

    // back-to-back loopback, even parity, two stop bits
    words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h3C;
    for (int w = 3; w < 8; w++) words[w] = 8'($urandom_range(0, 255));
    for (int w = 0; w < 8; w++) begin
      txd1 = words[w]; txv1 = 1'b1;
      k = 0;
      while (!txr1 && k < 1000) begin @(negedge clk); k++; end
      acc[w] = cyc;
      @(negedge clk);
    end
    txv1 = 1'b0;
    for (int w = 1; w < 8; w++) chk($sformatf("lb_gap%0d", w), 32'(acc[w] - acc[w-1]), 12 * CPB);
    wait_q(1, 8, 500, "lb_count");
    for (int w = 0; w < 8; w++)
      if (q1.size() > 0) chk($sformatf("lb_word%0d", w), 32'(q1.pop_front()), 32'({2'b00, words[w]}));

    // 7O1 receive: wrong then right parity on 0x41, then random words
    @(negedge clk);
    drive_frame(2, 8'h41, 7, 1, 1, 1'b1, BITNS);
    expect_rx(2, "p_bad_41", {1'b0, 1'b1, 8'h41});
    drive_frame(2, 8'h41, 7, 1, 1, 1'b0, BITNS);
    expect_rx(2, "p_good_41", {1'b0, 1'b0, 8'h41});
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 127));
      bad = 1'($urandom_range(0, 1));
      drive_frame(2, d, 7, 1, 1, bad, BITNS);
      expect_rx(2, $sformatf("p_rand%0d", i), {1'b0, bad, d});
    end

    // 8N1 random receive
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom_range(0, 255));
      drive_frame(0, d, 8, 0, 1, 1'b0, BITNS);
      expect_rx(0, $sformatf("rx_rand%0d", i), {2'b00, d});
    end

    // glitch: 4-cycle low pulse is not a start bit
    @(negedge clk);
    rx0 = 1'b0;
    repeat (4) @(negedge clk);
    rx0 = 1'b1;
    repeat (60) @(negedge clk);
    chk("glitch_no_strobe", 32'(q0.size()), 0);

    // break: 30 bit periods low gives one framing-error strobe
    rx0 = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    chk("break_one_strobe", 32'(q0.size()), 1);
    rx0 = 1'b1;
    repeat (40) @(negedge clk);
    expect_rx(0, "break_word", {1'b1, 1'b0, 8'h00});
    chk("break_no_more", 32'(q0.size()), 0);
    drive_frame(0, 8'h5A, 8, 0, 1, 1'b0, BITNS);
    expect_rx(0, "after_break", {2'b00, 8'h5A});

    // sender clock off by about 3% either way: over a 10-bit frame a full cycle
    // per bit would drift more than half a bit, so half-cycle offsets are used
    @(negedge clk);
    drive_frame(0, 8'h55, 8, 0, 1, 1'b0, BITNS - 5);
    expect_rx(0, "tol_fast", {2'b00, 8'h55});
    drive_frame(0, 8'h55, 8, 0, 1, 1'b0, BITNS + 5);
    expect_rx(0, "tol_slow", {2'b00, 8'h55});

    // reset during TX data bits and RX data bit 3
    repeat (4) @(negedge clk);
    txd0 = 8'h00; txv0 = 1'b1; rx0 = 1'b0;
    for (int j = 1; j <= 72; j++) begin
      @(negedge clk);
      txv0 = 1'b0;
      rx0 = fbit(8'hF0, j / CPB, 8);
    end
    chk("rst_pre_tx_low", 32'(tx0), 0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_tx_async", 32'(tx0), 1);
    chk("rst_tx_ready", 32'(txr0), 1);
    chk("rst_rx_valid", 32'(rxv0), 0);
    rx0 = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("rst_no_strobe", 32'(q0.size()), 0);
    drive_frame(0, 8'hC3, 8, 0, 1, 1'b0, BITNS);
    expect_rx(0, "rst_next_frame", {2'b00, 8'hC3});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
